// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write arbiter: engine command encodings,
// completion status codes, FSM states and the known slave address byte.
package i2c_pkg;

  // Engine command encodings (eng_cmd)
  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;

  // Completion status reported on err alongside done
  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ANACK = 2'd1;
  localparam logic [1:0] ERR_DNACK = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  // Address byte (7-bit 0x4C + W) of the slave on this bus
  localparam logic [7:0] SLAVE_ADDR_W = 8'h98;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req  : request vector
//   ptr  : highest-priority index this round
//   any  : at least one request set
//   oh   : one-hot winner
//   idx  : winner index
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] oh,
  output logic [IW-1:0]      idx
);

  always_comb begin
    int j;
    j   = 0;
    any = 1'b0;
    oh  = '0;
    idx = '0;
    // Scan upward from ptr, wrapping; first set bit wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any   = 1'b1;
        oh[j] = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_write_arbiter.sv
// Shares one byte-level I2C master engine between NUM_REQ requesters, each
// issuing a single-byte write (START, addr+W, data, STOP). Round-robin grant.
//   clk, reset        : clock, async active-low reset
//   req/req_addr/data : per-requester level request, 7-bit address, data byte
//   gnt/done/err      : one-hot grant, done pulse, status valid with done
//   busy              : FSM not idle
//   eng_cmd_*         : command handshake toward the master engine
//   eng_done/eng_nack : engine completion pulse and slave NACK flag
module i2c_write_arbiter
  import i2c_pkg::*;
#(
  parameter  int          NUM_REQ     = 2,
  parameter  logic [15:0] TIMEOUT_CYC = 16'd50000,
  localparam int          IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [1:0]           err,
  output logic                 busy,
  output logic                 eng_cmd_valid,
  output logic [1:0]           eng_cmd,
  output logic [7:0]           eng_cmd_data,
  input  logic                 eng_cmd_ready,
  input  logic                 eng_done,
  input  logic                 eng_nack
);

  state_t               state_q, state_d;
  logic [IW-1:0]        win_q, win_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]           abyte_q, abyte_d;
  logic [7:0]           dbyte_q, dbyte_d;
  logic [1:0]           stat_q, stat_d;
  logic [1:0]           err_q, err_d;
  logic                 acc_q, acc_d;   // command accepted, awaiting eng_done
  logic [15:0]          cnt_q, cnt_d;

  logic                 arb_any;
  logic [NUM_REQ-1:0]   arb_oh;
  logic [IW-1:0]        arb_idx;

  logic cmd_st, valid_c, hs, cmd_fin, tmo;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req),
    .ptr (rr_q),
    .any (arb_any),
    .oh  (arb_oh),
    .idx (arb_idx)
  );

  always_comb begin
    cmd_st  = (state_q == ST_START) || (state_q == ST_ADDR) ||
              (state_q == ST_DATA)  || (state_q == ST_STOP);
    valid_c = cmd_st && !acc_q;
    hs      = valid_c && eng_cmd_ready;
    // A handshake and eng_done in the same cycle completes the command;
    // eng_done with nothing outstanding is ignored.
    cmd_fin = cmd_st && (acc_q || hs) && eng_done;
    tmo     = cmd_st && (cnt_q == TIMEOUT_CYC - 16'd1);
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    abyte_d = abyte_q;
    dbyte_d = dbyte_q;
    stat_d  = stat_q;
    err_d   = err_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_START;
          win_d   = arb_idx;
          gnt_d   = arb_oh;
          abyte_d = {req_addr[int'(arb_idx)*7 +: 7], 1'b0};
          dbyte_d = req_data[int'(arb_idx)*8 +: 8];
          stat_d  = ERR_OK;
        end
      end
      ST_START: begin
        if (cmd_fin) begin
          state_d = ST_ADDR;
        end else if (tmo) begin
          stat_d  = ERR_TMO;
          state_d = ST_STOP;
        end
      end
      ST_ADDR: begin
        if (cmd_fin) begin
          if (eng_nack) begin
            stat_d  = ERR_ANACK;
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else if (tmo) begin
          stat_d  = ERR_TMO;
          state_d = ST_STOP;
        end
      end
      ST_DATA: begin
        if (cmd_fin) begin
          if (eng_nack) stat_d = ERR_DNACK;
          state_d = ST_STOP;
        end else if (tmo) begin
          stat_d  = ERR_TMO;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // A STOP that times out is not retried: finish straight away.
        if (cmd_fin) begin
          err_d   = stat_q;
          state_d = ST_FIN;
        end else if (tmo) begin
          err_d   = ERR_TMO;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        rr_d    = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake tracking and timeout counter restart on every state entry.
    if (state_d != state_q) begin
      acc_d = 1'b0;
      cnt_d = '0;
    end else if (cmd_st) begin
      acc_d = acc_q | hs;
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      abyte_q <= '0;
      dbyte_q <= '0;
      stat_q  <= ERR_OK;
      err_q   <= ERR_OK;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      abyte_q <= abyte_d;
      dbyte_q <= dbyte_d;
      stat_q  <= stat_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    gnt           = gnt_q;
    done          = (state_q == ST_FIN) ? (NUM_REQ'(1) << win_q) : '0;
    err           = err_q;
    busy          = (state_q != ST_IDLE);
    eng_cmd_valid = valid_c;
    eng_cmd       = CMD_START;
    eng_cmd_data  = 8'h00;
    case (state_q)
      ST_ADDR: begin eng_cmd = CMD_WRITE; eng_cmd_data = abyte_q; end
      ST_DATA: begin eng_cmd = CMD_WRITE; eng_cmd_data = dbyte_q; end
      ST_STOP: eng_cmd = CMD_STOP;
      default: ;
    endcase
  end

endmodule
